// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full
// Description : Write-side pointer and flag generator for a dual-clock FIFO.
//               Holds the binary write pointer, publishes a registered Gray
//               copy for the read-domain synchronizer, and produces
//               registered full / almost-full / level / sticky-overflow flags
//               against a read pointer already synchronized into clk.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   write-domain clock
//   rst_n        in   asynchronous active-low reset
//   winc         in   write request
//   clr_ovf      in   synchronous clear of sticky overflow
//   rgray_sync   in   [ADDR_W:0] synchronized Gray read pointer
//   waddr        out  [ADDR_W-1:0] RAM write address
//   wbin         out  [ADDR_W:0] binary write pointer (with wrap bit)
//   wgray        out  [ADDR_W:0] registered Gray write pointer
//   wfull        out  FIFO full
//   walmost_full out  free slots <= ALMOST_GAP
//   wlevel       out  [ADDR_W:0] occupancy seen from the write domain
//   wovf         out  sticky: write attempted while full
// ============================================================================
module fifo_wptr_full #(
  parameter int ADDR_W     = 3,
  parameter int ALMOST_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic              clr_ovf,
  input  logic [ADDR_W:0]   rgray_sync,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wbin,
  output logic [ADDR_W:0]   wgray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf
);

  // Occupancy at or above this threshold leaves ALMOST_GAP or fewer free slots.
  localparam logic [ADDR_W:0] ALMOST_THR = (ADDR_W+1)'((1 << ADDR_W) - ALMOST_GAP);

  logic            we;
  logic [ADDR_W:0] bin_next;
  logic [ADDR_W:0] gray_next;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] level_next;
  logic [ADDR_W:0] full_pattern;
  logic            full_next;
  logic            almost_next;
  logic            ovf_next;

  // Uses the registered wfull, so a write coinciding with a read-pointer
  // advance while full is still rejected.
  assign we        = winc & ~wfull;
  assign bin_next  = wbin + {{ADDR_W{1'b0}}, we};
  assign gray_next = bin_next ^ (bin_next >> 1);

  // Gray-to-binary decode of the synchronized read pointer: each binary bit
  // is the XOR of all Gray bits from the MSB down to that position.
  for (genvar i = 0; i <= ADDR_W; i++) begin : g_g2b
    assign rbin[i] = ^rgray_sync[ADDR_W:i];
  end

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // means the two MSBs are inverted and the remaining bits match.
  assign full_pattern = {~rgray_sync[ADDR_W:ADDR_W-1], rgray_sync[ADDR_W-2:0]};
  assign full_next    = (gray_next == full_pattern);

  assign level_next  = bin_next - rbin;
  assign almost_next = (level_next >= ALMOST_THR);

  // Set wins over clear so an overflow in the clearing cycle is not lost.
  assign ovf_next = (winc & wfull) ? 1'b1 : (clr_ovf ? 1'b0 : wovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin         <= '0;
      wgray        <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= bin_next;
      wgray        <= gray_next;
      wfull        <= full_next;
      walmost_full <= almost_next;
      wlevel       <= level_next;
      wovf         <= ovf_next;
    end
  end

  assign waddr = wbin[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wptr_full
// Description : Self-checking bench for fifo_wptr_full. A counting model
//               (total writes / total reads as plain integers) predicts every
//               output; directed fill/overflow/wrap/reset sequences are
//               followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_full;

  localparam int ADDR_W = 3;
  localparam int GAP    = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MOD    = 2 * DEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              winc = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [ADDR_W:0]   rgray_sync = '0;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wbin;
  logic [ADDR_W:0]   wgray;
  logic              wfull;
  logic              walmost_full;
  logic [ADDR_W:0]   wlevel;
  logic              wovf;

  fifo_wptr_full #(.ADDR_W(ADDR_W), .ALMOST_GAP(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .clr_ovf      (clr_ovf),
    .rgray_sync   (rgray_sync),
    .waddr        (waddr),
    .wbin         (wbin),
    .wgray        (wgray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 clk = ~clk;

  // Model state: total accepted writes and total reads since reset.
  int wtot, rtot;
  bit m_ovf, m_full, m_accept;
  logic [ADDR_W:0] prev_gray;
  int n_checks, n_fail;

  function automatic logic [ADDR_W:0] to_gray(input int b);
    int v;
    v = b % MOD;
    return (ADDR_W+1)'(v ^ (v >> 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wtot = 0; rtot = 0; m_ovf = 0; m_full = 0; m_accept = 0; prev_gray = '0;
  endtask

  task automatic compare_all();
    int lvl;
    lvl = wtot - rtot;
    check("wbin",   32'(wbin),   32'(wtot % MOD));
    check("waddr",  32'(waddr),  32'(wtot % DEPTH));
    check("wgray",  32'(wgray),  32'(to_gray(wtot)));
    check("wlevel", 32'(wlevel), 32'(lvl));
    check("wfull",  32'(wfull),  32'(lvl == DEPTH));
    check("walmost_full", 32'(walmost_full), 32'(lvl >= DEPTH - GAP));
    check("wovf",   32'(wovf),   32'(m_ovf));
    check("gray_step", 32'($countones(wgray ^ prev_gray)), 32'(m_accept));
    prev_gray = wgray;
  endtask

  // Called at a negedge: apply inputs, take one rising edge, advance the
  // model, then compare on the following falling edge.
  task automatic step(input bit w, input bit c);
    winc       = w;
    clr_ovf    = c;
    rgray_sync = to_gray(rtot);
    @(posedge clk);
    m_accept = w && !m_full;
    if (w && m_full) m_ovf = 1;
    else if (c)      m_ovf = 0;
    if (m_accept) wtot++;
    m_full = ((wtot - rtot) == DEPTH);
    @(negedge clk);
    compare_all();
  endtask

  logic [ADDR_W:0] fill_gray [8];
  int hist [$];
  bit saw_wrap;

  initial begin
    fill_gray = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    n_checks = 0; n_fail = 0;
    model_reset();

    // Reset held with winc toggling: everything stays zero.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      winc = ~winc;
      compare_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0);

    // Fill eight entries against an empty read pointer.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0);
      check("fill_gray", 32'(wgray), 32'(fill_gray[i]));
      check("fill_bin",  32'(wbin),  32'(i + 1));
    end
    check("fill_full", 32'(wfull), 32'd1);

    // Overflow set / clear / set-over-clear.
    step(1, 0);
    check("ovf_hold_bin", 32'(wbin), 32'd8);
    check("ovf_set", 32'(wovf), 32'd1);
    step(0, 1);
    check("ovf_clr", 32'(wovf), 32'd0);
    step(1, 0);
    step(1, 1);
    check("ovf_set_prio", 32'(wovf), 32'd1);
    step(0, 1);

    // One read frees a slot.
    rtot = 1;
    step(0, 0);
    check("rel_full", 32'(wfull), 32'd0);
    check("rel_level", 32'(wlevel), 32'd7);

    // Sixteen writes with the read pointer trailing by two cycles.
    hist.delete();
    hist.push_back(wtot);
    hist.push_back(wtot);
    saw_wrap = 0;
    for (int i = 0; i < 16; i++) begin
      rtot = hist[hist.size() - 2];
      step(1, 0);
      if (wbin == 0 && m_accept) saw_wrap = 1;
      hist.push_back(wtot);
    end
    check("wrap_seen", 32'(saw_wrap), 32'd1);

    // Randomized phase: reader rate alternates so full is reached often.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit fast;
      fast = ((cyc / 40) % 2) == 1;
      if (rtot < wtot && ($urandom_range(0, 3) < (fast ? 3 : 1)))
        rtot += $urandom_range(1, (wtot - rtot > 2) ? 2 : (wtot - rtot));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset mid-fill.
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("areset_bin",   32'(wbin),   32'd0);
    check("areset_gray",  32'(wgray),  32'd0);
    check("areset_level", 32'(wlevel), 32'd0);
    check("areset_almost", 32'(walmost_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0);
    check("restart_bin", 32'(wbin), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and flag generator for the dual-clock FIFO. It is the encoding counterpart of the Gray-to-binary decoder used on the read side. It holds the binary write pointer, publishes a registered Gray-coded copy for synchronization into the read domain, and computes registered full, almost-full, fill-level and overflow flags. It compares against the read pointer after that pointer has already been synchronized into this clock domain.

## Interface
- ADDR_W, 3: FIFO address width. Depth = 2**ADDR_W. Legal range ADDR_W >= 2.
- ALMOST_GAP, 2: walmost_full asserts when free slots <= ALMOST_GAP. Legal range 1..2**ADDR_W-1.

- clk  input  1  write-domain clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request for this cycle.
- clr_ovf  input  1  synchronous clear of the sticky overflow flag.
- rgray_sync  input  ADDR_W+1  read pointer, Gray-coded, already 2-flop synchronized into clk.
- waddr  output  ADDR_W  RAM write address = wbin[ADDR_W-1:0].
- wbin  output  ADDR_W+1  binary write pointer, including the wrap bit.
- wgray  output  ADDR_W+1  registered Gray write pointer for the read-domain synchronizer.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  free slots <= ALMOST_GAP, registered.
- wlevel  output  ADDR_W+1  occupancy as seen from the write domain, 0..2**ADDR_W.
- wovf  output  1  sticky flag: a write was attempted while full.

## Operation
- Accepted write: we = winc & ~wfull.
- Next pointer: bin_next = wbin + we, modulo 2**(ADDR_W+1).
- Gray encoding: gray_next = bin_next ^ (bin_next >> 1).
- Register updates each edge:
  - wbin <= bin_next.
  - wgray <= gray_next.
  - wgray always changes by exactly one bit per accepted write, including the wrap from all-ones to zero.
- Read pointer decode: rbin = Gray-to-binary of rgray_sync. Bit i = XOR of rgray_sync bits ADDR_W down to i.
- Full detect: wfull <= (gray_next == {~rgray_sync[ADDR_W:ADDR_W-1], rgray_sync[ADDR_W-2:0]}).
- Level: wlevel <= bin_next - rbin, modulo 2**(ADDR_W+1).
- Almost full: walmost_full <= (bin_next - rbin) >= 2**ADDR_W - ALMOST_GAP.
- Overflow: set when winc & wfull. Cleared only when clr_ovf=1 and no overflow occurs in the same cycle; set has priority over clear.
- Rejected write (winc while wfull): pointers do not move and no RAM write is implied. The rejection is flagged by wovf only.
- No state machine. The block is a pointer register plus flag pipeline. All outputs are flops except waddr, which is a direct slice of wbin.

## Timing
- Reset (rst_n low, asynchronous): wbin=0, wgray=0, wfull=0, walmost_full=0, wlevel=0, wovf=0. Release is used synchronously on the next edge.
- Write latency: winc sampled at edge N moves wbin, wgray and wlevel at edge N.
- Full latency:
  - The write that fills the FIFO asserts wfull at the same edge as the pointer update.
  - A winc at the next edge is rejected.
- Full release: a change on rgray_sync sampled at edge N updates wfull, walmost_full and wlevel at edge N. Deassertion is pessimistic only because of the upstream synchronizer, not this block.
- Simultaneous winc with a read-pointer advance while full: the write is still rejected, because wfull is the registered value. wfull deasserts at that edge.
- Wrap: wbin goes from 2**(ADDR_W+1)-1 to 0. The wrap bit distinguishes full from empty.
- Reset mid-operation: all outputs return to reset values immediately. The read side must be reset in the same reset event.

## Test plan
- Reset: hold rst_n=0 with winc=1 toggling → all outputs 0. Release rst_n with winc=0 → outputs stay 0.
- Fill (ADDR_W=3, rgray_sync=0): 8 consecutive winc → wgray sequence 1,3,2,6,7,5,4,12 and wbin 1..8. wfull=1 at the 8th edge. wlevel=8.
- Almost full (ALMOST_GAP=2): same fill → walmost_full rises at the 6th write edge (wlevel=6) and stays high.
- Overflow: with wfull=1, pulse winc → wbin holds 8 and wovf=1. Pulse clr_ovf → wovf=0 next edge. Assert winc and clr_ovf together while full → wovf stays 1.
- Release and wrap: from full, set rgray_sync=1 (rbin=1) → wfull=0 and wlevel=7 next edge. Then drive 16 writes with rgray_sync tracking wgray delayed 2 cycles → wbin wraps 15→0, wgray goes 8→0, and every wgray transition differs in exactly one bit.
- Asynchronous reset mid-fill: after 5 writes, assert rst_n between edges → outputs clear without a clock edge. Restart yields wbin=1 after the first write.
